// File: rtl/fp_vec_pkg.sv
// Shared FP vector types for the drain wrapper and FPVectorAdd benches.
// Lane format is {sign, exponent, mantissa}; lane 0 sits in the low bits.
package fp_vec_pkg;
    localparam int DEF_EXP_BITS  = 5;
    localparam int DEF_MANT_BITS = 6;
    localparam int DEF_LANES     = 4;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_ID_BITS   = 32;

    function automatic int lane_w(input int exp_bits, input int mant_bits);
        return 1 + exp_bits + mant_bits;
    endfunction

    localparam int W = lane_w(DEF_EXP_BITS, DEF_MANT_BITS);

    typedef logic [W-1:0] fp_lane_t;
    typedef fp_lane_t [DEF_LANES-1:0] fp_vec_t;
endpackage

// File: rtl/fp_vec_add_drain_if.sv
// Operand-in / result-out handshake bundle of fp_vec_add_drain.
// slave = wrapper side, master = the agent feeding operands and draining results.
interface fp_vec_add_drain_if #(
    parameter int ID_BITS = 32,
    parameter int VW      = 48
);
    logic               s_valid;
    logic               s_ready;
    logic [ID_BITS-1:0] s_id;
    logic [VW-1:0]      s_op1;
    logic [VW-1:0]      s_op2;
    logic               m_valid;
    logic               m_ready;
    logic [ID_BITS-1:0] m_id;
    logic [VW-1:0]      m_sum;

    modport slave (
        input  s_valid, s_id, s_op1, s_op2, m_ready,
        output s_ready, m_valid, m_id, m_sum
    );
    modport master (
        output s_valid, s_id, s_op1, s_op2, m_ready,
        input  s_ready, m_valid, m_id, m_sum
    );
endinterface

// File: rtl/fp_vec_add_drain_sync_fifo.sv
// Single-clock FIFO with combinational head read; used for the tag queue and result buffer.
// Reads when empty are ignored; writes when full are dropped unless a read frees a slot.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_wr, do_rd;

    assign do_rd   = rd_en & (cnt != '0);
    assign do_wr   = wr_en & ((cnt != (AW+1)'(DEPTH)) | do_rd);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/fp_vec_add_drain.sv
// Issue/collect wrapper around a fixed-latency, no-stall FP vector adder.
// Define FP_VEC_DRAIN_ERR_EN to build the sticky protocol-error checker on err.
module fp_vec_add_drain
    import fp_vec_pkg::*;
#(
    parameter int  EXP_BITS  = DEF_EXP_BITS,
    parameter int  MANT_BITS = DEF_MANT_BITS,
    parameter int  LANES     = DEF_LANES,
    parameter int  DEPTH     = DEF_DEPTH,
    parameter int  ID_BITS   = DEF_ID_BITS,
    localparam int VW        = LANES * lane_w(EXP_BITS, MANT_BITS)
) (
    input  logic              clk,
    input  logic              rst,
    fp_vec_add_drain_if.slave bus,
    output logic              add_in_valid,
    output logic [VW-1:0]     add_op1,
    output logic [VW-1:0]     add_op2,
    input  logic              add_out_valid,
    input  logic [VW-1:0]     add_sum,
    output logic              err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         inflight, count;
    logic                  up, issue, ret, wr, pop;
    logic [ID_BITS-1:0]    tag;
    logic [ID_BITS+VW-1:0] res_head;

    // Credit covers both ops still in the adder and results still buffered,
    // so the adder can never return into a full FIFO.
    assign bus.s_ready = up & (({1'b0, inflight} + {1'b0, count}) < (CW+1)'(DEPTH));
    assign issue        = bus.s_valid & bus.s_ready;
    assign add_in_valid = issue;
    assign add_op1      = bus.s_op1;
    assign add_op2      = bus.s_op2;

    assign bus.m_valid = count != '0;
    assign pop         = bus.m_valid & bus.m_ready;
    assign {bus.m_id, bus.m_sum} = res_head;

`ifdef FP_VEC_DRAIN_ERR_EN
    logic spurious, ovf, err_q;

    assign spurious = add_out_valid & (inflight == '0);
    assign ret      = add_out_valid & ~spurious;
    assign ovf      = ret & (count == CW'(DEPTH)) & ~pop;
    assign wr       = ret & ~ovf;
    assign err      = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  err_q <= 1'b0;
        else if (spurious || ovf) err_q <= 1'b1;
    end
`else
    assign ret = add_out_valid;
    assign wr  = ret;
    assign err = 1'b0;
`endif

    // up holds s_ready low through reset and the first cycle after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up       <= 1'b0;
            inflight <= '0;
            count    <= '0;
        end else begin
            up       <= 1'b1;
            inflight <= inflight + CW'(issue) - CW'(ret);
            count    <= count + CW'(wr) - CW'(pop);
        end
    end

    sync_fifo #(.WIDTH(ID_BITS), .DEPTH(DEPTH)) u_tag_q (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (issue),
        .wr_data (bus.s_id),
        .rd_en   (ret),
        .rd_data (tag)
    );

    sync_fifo #(.WIDTH(ID_BITS + VW), .DEPTH(DEPTH)) u_res_q (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data ({tag, add_sum}),
        .rd_en   (pop),
        .rd_data (res_head)
    );
endmodule

// File: tb/tb_fp_vec_add_drain.sv
// Directed bench for fp_vec_add_drain with a 2-cycle stand-in adder that doubles op1
// (exponent + 1); every vector uses op1 == op2 so that is the true FP sum.
module tb_fp_vec_add_drain;
    import fp_vec_pkg::*;

    localparam int VW = DEF_LANES * W;
    localparam logic [VW-1:0] V314 = 48'h424424424424;
    localparam logic [VW-1:0] V628 = 48'h464464464464;

    logic clk = 1'b0;
    logic rst;
    logic add_in_valid, add_out_valid, err, force_ov;
    logic [VW-1:0] add_op1, add_op2, add_sum;

    always #5 clk = ~clk;

    fp_vec_add_drain_if #(.ID_BITS(DEF_ID_BITS), .VW(VW)) bus ();

    fp_vec_add_drain dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .add_in_valid  (add_in_valid),
        .add_op1       (add_op1),
        .add_op2       (add_op2),
        .add_out_valid (add_out_valid),
        .add_sum       (add_sum),
        .err           (err)
    );

    function automatic fp_vec_t dbl(input fp_vec_t v);
        fp_vec_t r;
        for (int i = 0; i < DEF_LANES; i++) begin
            r[i] = v[i];
            r[i][W-2 -: DEF_EXP_BITS] = v[i][W-2 -: DEF_EXP_BITS] + DEF_EXP_BITS'(1);
        end
        return r;
    endfunction

    function automatic fp_vec_t mk_op(input int id);
        fp_vec_t v;
        for (int i = 0; i < DEF_LANES; i++)
            v[i] = {1'b0, DEF_EXP_BITS'(id + 8), DEF_MANT_BITS'(id + i)};
        return v;
    endfunction

    function automatic fp_vec_t mk_sum(input int id);
        fp_vec_t v;
        for (int i = 0; i < DEF_LANES; i++)
            v[i] = {1'b0, DEF_EXP_BITS'(id + 9), DEF_MANT_BITS'(id + i)};
        return v;
    endfunction

    // Stand-in adder: fixed 2-cycle latency, cleared by the shared reset.
    logic [1:0] pv;
    fp_vec_t    ps0, ps1;
    always @(posedge clk or posedge rst) begin
        if (rst) pv <= 2'b00;
        else begin
            pv  <= {pv[0], add_in_valid};
            ps0 <= dbl(add_op1);
            ps1 <= ps0;
        end
    end
    assign add_out_valid = pv[1] | force_ov;
    assign add_sum       = ps1;

    logic [DEF_ID_BITS-1:0] got_id[$];
    logic [VW-1:0]          got_sum[$];
    always @(negedge clk) begin
        if (!rst && bus.m_valid && bus.m_ready) begin
            got_id.push_back(bus.m_id);
            got_sum.push_back(bus.m_sum);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int id, input logic [VW-1:0] op);
        int k = 0;
        bus.s_valid = 1'b1;
        bus.s_id    = DEF_ID_BITS'(id);
        bus.s_op1   = op;
        bus.s_op2   = op;
        while (!bus.s_ready && k < 40) begin
            tick();
            k++;
        end
        chk("send_ready", 64'(bus.s_ready), 64'(1));
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_q(input int n, input string tag);
        int k = 0;
        while (got_id.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk(tag, 64'(got_id.size()), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        force_ov = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_id = '0;
        bus.s_op1 = '0;
        bus.s_op2 = '0;
        bus.m_ready = 1'b0;
        tick();
        tick();
        chk("rst_s_ready", 64'(bus.s_ready), 64'(0));
        chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", 64'(bus.s_ready), 64'(1));

        // single op, exact latency: return on cycle 2, m_valid on cycle 3
        bus.s_valid = 1'b1;
        bus.s_id = 1;
        bus.s_op1 = V314;
        bus.s_op2 = V314;
        #1;
        chk("t1_add_in_valid", 64'(add_in_valid), 64'(1));
        chk("t1_add_op1", 64'(add_op1), 64'(V314));
        chk("t1_add_op2", 64'(add_op2), 64'(V314));
        tick();
        bus.s_valid = 1'b0;
        tick();
        chk("t1_add_out_valid", 64'(add_out_valid), 64'(1));
        chk("t1_m_valid_early", 64'(bus.m_valid), 64'(0));
        tick();
        chk("t1_m_valid", 64'(bus.m_valid), 64'(1));
        chk("t1_m_id", 64'(bus.m_id), 64'(1));
        chk("t1_m_sum", 64'(bus.m_sum), 64'(V628));
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("t1_m_valid_after_pop", 64'(bus.m_valid), 64'(0));
        got_id.delete();
        got_sum.delete();

        // fill to DEPTH under backpressure
        for (int id = 1; id <= DEF_DEPTH; id++) send(id, mk_op(id));
        chk("t2_full_s_ready", 64'(bus.s_ready), 64'(0));
        bus.s_valid = 1'b1;
        bus.s_id = 99;
        #1;
        chk("t2_ignored_issue", 64'(add_in_valid), 64'(0));
        repeat (6) tick();
        chk("t2_still_full", 64'(bus.s_ready), 64'(0));
        chk("t2_head_held", 64'(bus.m_id), 64'(1));
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        wait_q(DEF_DEPTH, "t2_drain_count");
        bus.m_ready = 1'b0;
        for (int i = 0; i < DEF_DEPTH && i < got_id.size(); i++) begin
            chk("t2_order_id", 64'(got_id[i]), 64'(i + 1));
            chk("t2_order_sum", 64'(got_sum[i]), 64'(mk_sum(i + 1)));
        end
        got_id.delete();
        got_sum.delete();

        // steady stream: one accept every cycle
        bus.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid = 1'b1;
            bus.s_id = DEF_ID_BITS'(10 + i);
            bus.s_op1 = mk_op(10 + i);
            bus.s_op2 = mk_op(10 + i);
            chk("t3_stream_ready", 64'(bus.s_ready), 64'(1));
            tick();
        end
        bus.s_valid = 1'b0;
        wait_q(8, "t3_drain_count");
        for (int i = 0; i < 8 && i < got_id.size(); i++) begin
            chk("t3_order_id", 64'(got_id[i]), 64'(10 + i));
            chk("t3_order_sum", 64'(got_sum[i]), 64'(mk_sum(10 + i)));
        end
        got_id.delete();
        got_sum.delete();
        bus.m_ready = 1'b0;

        // full occupancy, then return+pop, then issue+return+pop in one cycle
        for (int id = 20; id < 24; id++) send(id, mk_op(id));
        chk("t4_full", 64'(bus.s_ready), 64'(0));
        chk("t4_head", 64'(bus.m_id), 64'(20));
        chk("t4_ret_pending", 64'(add_out_valid), 64'(1));
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_id = 24;
        bus.s_op1 = mk_op(24);
        bus.s_op2 = mk_op(24);
        #1;
        chk("t4_no_issue_at_full", 64'(add_in_valid), 64'(0));
        tick();
        chk("t4_ready_after_pop", 64'(bus.s_ready), 64'(1));
        chk("t4_issue", 64'(add_in_valid), 64'(1));
        chk("t4_ret", 64'(add_out_valid), 64'(1));
        chk("t4_head2", 64'(bus.m_id), 64'(21));
        tick();
        bus.s_valid = 1'b0;
        chk("t4_ready_steady", 64'(bus.s_ready), 64'(1));
        chk("t4_head3", 64'(bus.m_id), 64'(22));
        wait_q(5, "t4_drain_count");
        for (int i = 0; i < 5 && i < got_id.size(); i++)
            chk("t4_order_id", 64'(got_id[i]), 64'(20 + i));
        got_id.delete();
        got_sum.delete();
        bus.m_ready = 1'b0;
        repeat (2) tick();
        chk("t4_empty_m_valid", 64'(bus.m_valid), 64'(0));
        chk("t4_empty_s_ready", 64'(bus.s_ready), 64'(1));

        // reset with ops outstanding
        for (int id = 30; id < 33; id++) send(id, mk_op(id));
        rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", 64'(bus.m_valid), 64'(0));
        chk("t5_rst_s_ready", 64'(bus.s_ready), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t5_ready_after_rst", 64'(bus.s_ready), 64'(1));
        chk("t5_nothing_left", 64'(bus.m_valid), 64'(0));
        send(40, mk_op(40));
        begin
            int k = 0;
            while (!bus.m_valid && k < 20) begin
                tick();
                k++;
            end
        end
        chk("t5_m_valid", 64'(bus.m_valid), 64'(1));
        chk("t5_m_id", 64'(bus.m_id), 64'(40));
        chk("t5_m_sum", 64'(bus.m_sum), 64'(mk_sum(40)));
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("t5_drained", 64'(bus.m_valid), 64'(0));
        got_id.delete();
        got_sum.delete();

        // spurious adder return with nothing in flight
        force_ov = 1'b1;
        tick();
        force_ov = 1'b0;
`ifdef FP_VEC_DRAIN_ERR_EN
        chk("t6_err_set", 64'(err), 64'(1));
        chk("t6_no_result", 64'(bus.m_valid), 64'(0));
        repeat (3) tick();
        chk("t6_err_held", 64'(err), 64'(1));
`else
        chk("t6_err_tied", 64'(err), 64'(0));
        repeat (3) tick();
        chk("t6_err_still_0", 64'(err), 64'(0));
`endif
        rst = 1'b1;
        #1;
        chk("t6_err_rst", 64'(err), 64'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("t6_final_ready", 64'(bus.s_ready), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
